// File: rtl/huffman_pkg.sv
// Shared types and defaults for the Huffman bit packer and its output FIFO.
package huffman_pkg;

    localparam int WORD_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Entry layout for the default word width.
    typedef struct packed {
        logic [WORD_W_DEF-1:0]       data;
        logic [$clog2(WORD_W_DEF):0] bits;
        logic                        last;
    } entry_t;

endpackage

// File: rtl/huffman_sync_fifo.sv
// Synchronous FIFO with a clear input; the head entry is read straight from storage.
module huffman_sync_fifo
    import huffman_pkg::*;
#(
    parameter type data_t = logic [7:0],
    parameter int  DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic  Clk_in,
    input  logic  n_Rst,
    input  logic  clear,
    input  logic  push,
    input  data_t push_data,
    input  logic  pop,
    output data_t head,
    output logic  full,
    output logic  empty
);
    localparam int AW = $clog2(DEPTH);

    data_t         mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_q];

    always_ff @(posedge Clk_in) begin
        if (!n_Rst || clear) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge Clk_in) begin
        if (do_push) mem[wr_q] <= push_data;
    end

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs the serial Huffman code stream MSB-first into words and queues them for the consumer.
//   state | meaning
//   IDLE  | no frame; bits and flush ignored
//   RUN   | accepting bits, pushing full words
//   DRAIN | frame flushed, waiting for the FIFO to empty
module huffman_bit_packer
    import huffman_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter bit PAD_BIT    = 1'b0
) (
    input  logic                      Clk_in,
    input  logic                      n_Rst,
    input  logic                      Start,
    input  logic                      Bit_in,
    input  logic                      Bit_valid,
    input  logic                      Flush,
    output logic [WORD_W-1:0]         Word_out,
    output logic [$clog2(WORD_W):0]   Word_bits,
    output logic                      Word_last,
    output logic                      Word_valid,
    input  logic                      Word_ready,
    output logic                      Overflow,
    output logic                      Done,
    output logic                      Busy
);
    localparam int CW = $clog2(WORD_W) + 1;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [CW-1:0]     bits;
        logic              last;
    } word_entry_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d, data_after, pad_mask;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_after, shamt;
    logic              ovf_q, ovf_d, done_q, done_d;
    logic              push, pop, clear, full, empty;
    word_entry_t       push_entry, head;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        push       = 1'b0;
        clear      = 1'b0;
        push_entry = '0;
        data_after = Bit_valid ? {acc_q[WORD_W-2:0], Bit_in} : acc_q;
        cnt_after  = Bit_valid ? cnt_q + CW'(1) : cnt_q;
        shamt      = CW'(WORD_W) - cnt_after;
        pad_mask   = PAD_BIT ? ~({WORD_W{1'b1}} << shamt) : '0;
        pop        = !empty && Word_ready;

        if (Start) begin
            clear   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    acc_d = data_after;
                    // The completing bit is taken first; flush then sees the updated count.
                    if (cnt_after == CW'(WORD_W)) begin
                        push       = 1'b1;
                        push_entry = '{data: data_after, bits: CW'(WORD_W), last: Flush};
                        cnt_d      = '0;
                    end else if (Flush && cnt_after != '0) begin
                        push       = 1'b1;
                        push_entry = '{data: (data_after << shamt) | pad_mask,
                                       bits: cnt_after, last: 1'b1};
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_after;
                    end
                    if (Flush) state_d = DRAIN;
                end
                DRAIN: begin
                    if (Bit_valid) ovf_d = 1'b1;
                    if (empty) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
            if (push && full && !pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge Clk_in) begin
        if (!n_Rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    huffman_sync_fifo #(
        .data_t (word_entry_t),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .Clk_in    (Clk_in),
        .n_Rst     (n_Rst),
        .clear     (clear),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Stale storage is hidden while the FIFO is empty so idle outputs read as zero.
    assign Word_valid = !empty;
    assign Word_out   = empty ? '0 : head.data;
    assign Word_bits  = empty ? '0 : head.bits;
    assign Word_last  = !empty && head.last;
    assign Overflow   = ovf_q;
    assign Done       = done_q;
    assign Busy       = (state_q != IDLE);

endmodule

// File: doc/huffman_bit_packer.md
Name: huffman_bit_packer

Overview:
- Downstream stage of the Huffman encoder; consumes its serial code bitstream (one bit per strobe) and packs it MSB-first into WORD_W-bit words.
- Words are buffered in a small FIFO and handed to the storage/transmit stage over a valid/ready handshake.
- A frame is bracketed by Start and Flush. The final partial word is zero-padded and tagged with its valid-bit count.

Parameters:
- WORD_W, 8, packed word width in bits (power of 2, >=4).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).
- PAD_BIT, 0, fill value for unused LSBs of the final partial word.

Ports:
- Clk_in  in  1  system clock, rising edge.
- n_Rst  in  1  reset, synchronous, active-low.
- Start  in  1  single-cycle pulse; clears packer/FIFO/Overflow and begins a frame.
- Bit_in  in  1  encoder code bit.
- Bit_valid  in  1  Bit_in is valid this cycle.
- Flush  in  1  single-cycle pulse; ends the frame.
- Word_out  out  WORD_W  FIFO head word, first received bit in MSB.
- Word_bits  out  clog2(WORD_W)+1  count of valid bits in Word_out (1..WORD_W).
- Word_last  out  1  Word_out is the final word of the frame.
- Word_valid  out  1  FIFO non-empty.
- Word_ready  in  1  consumer accepts the head word when Word_valid && Word_ready.
- Overflow  out  1  sticky flag: a word or bit was dropped.
- Done  out  1  one-cycle pulse: frame fully drained.
- Busy  out  1  state != IDLE.

Behaviour:
- Reset (n_Rst=0 at a rising edge):
  - State=IDLE; accumulator and bit count=0; FIFO empty.
  - Word_out=0, Word_bits=0, Word_last=0, Word_valid=0, Overflow=0, Done=0, Busy=0.
  - Reset mid-frame discards all data with no Done pulse.
- FSM states and transitions:
  - IDLE: Start -> RUN. Bit_valid and Flush are ignored and do not set Overflow.
  - RUN: Flush -> DRAIN. Start -> clear everything, remain in RUN.
  - DRAIN: when the FIFO is empty -> Done pulses for 1 cycle -> IDLE. Bit_valid in DRAIN sets Overflow; the bit is discarded. Start in DRAIN -> clear everything, go to RUN, no Done pulse.
- Packing (RUN):
  - Each Bit_valid shifts Bit_in into the accumulator MSB-first and increments the count.
  - When the count reaches WORD_W, the word is pushed {data, Word_bits=WORD_W, last=0} and the count returns to 0.
- Latency:
  - Push occurs on the edge that accepts the completing bit.
  - Word_valid asserts the following cycle if the FIFO was empty (1-cycle latency).
- Flush in RUN:
  - Same cycle as Bit_valid: the bit is accepted first, then flush is evaluated on the updated count.
  - Count k>0: push {data left-aligned, LSBs=PAD_BIT, Word_bits=k, last=1}.
  - Count 0 with the last word just completed that same cycle: push that word with last=1.
  - Count 0 otherwise: no push; the frame ends with no last-tagged word.
- FIFO:
  - Pop on Word_valid && Word_ready. Outputs are driven from the head entry, registered.
  - Simultaneous push and pop when full is legal and loses no data.
  - Push when full without a same-cycle pop: word dropped, Overflow=1.
  - Overflow clears only on Start or reset.
- Width rules: Word_bits is never 0 for a pushed word. Counters wrap only via an explicit reset to 0.

Decomposition:
- Shared package huffman_pkg holds:
  - FSM state encoding (IDLE, RUN, DRAIN).
  - Default WORD_W and FIFO_DEPTH.
  - Packed entry struct {data, bits, last}.
- Sub-module huffman_sync_fifo: parameterised synchronous FIFO with push/pop/full/empty, same Clk_in/n_Rst.
- Packer and FSM live in the top.

Test Plan:
- Reset, Start, Bit_valid bits 1,0,1,1,0,0,1,0, Word_ready=1 -> Word_out=0xB2, Word_bits=8, Word_last=0, valid 1 cycle after 8th bit.
- Bits 1,1,0 then Flush -> Word_out=0xC0, Word_bits=3, Word_last=1; Done pulses 1 cycle after pop; Busy drops with Done.
- 8th bit (pattern 0xFF) and Flush in the same cycle -> single word 0xFF, Word_bits=8, Word_last=1; no extra word.
- Word_ready=0, 40 bits (5 words) -> Word_valid held, 4 words retained, Overflow=1. Release Word_ready -> first 4 words emerge in order; Start -> Overflow=0.
- Full FIFO, Word_ready=1 on the same cycle as a push -> no drop, Overflow stays 0.
- n_Rst=0 for 1 cycle after 5 bits mid-frame -> all outputs at reset values, no Done. Next Start plus 8 bits 0x5A -> Word_out=0x5A.
